// File: rtl/y86_pipe_ctrl_pkg.sv
// Y86-64 shared encodings: icodes, stats, register ids and control states.
// Imported by every pipeline stage and by the pipeline control block.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;
  localparam logic [3:0] S_INS = 4'd4;
  localparam logic [3:0] S_TMO = 4'd5;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_STOP = 2'd1;
  localparam logic [1:0] ST_TMO  = 2'd2;

  function automatic logic is_stop_stat(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// Bundle between the pipeline stage registers and the control block.
// master = pipeline side, slave = control block.
interface y86_pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;
  logic [3:0]       W_icode;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic [1:0]       state;
  logic [3:0]       final_stat;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
    output M_icode, m_stat, W_stat, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble,
    input  W_stall, set_cc, state, final_stat,
    input  cycle_cnt, retire_cnt, stall_cnt, mispred_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
    input  M_icode, m_stat, W_stat, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble,
    output W_stall, set_cc, state, final_stat,
    output cycle_cnt, retire_cnt, stall_cnt, mispred_cnt
  );
endinterface

// File: rtl/y86_pipe_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module y86_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // count up while enabled, stick at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: hazard stalls/bubbles, cc enable,
// run/stop/timeout state, latched final status and perf counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RET_BUBBLES = 3,
  parameter int WDOG_CYCLES = 0
) (
  input logic             clk,
  input logic             rst_n,
  y86_pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] RET_LOAD = 3'(RET_BUBBLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST =
    CNT_W'((WDOG_CYCLES == 0) ? 0 : (WDOG_CYCLES - 1));

  logic [2:0]       r_ret_cnt;
  logic [1:0]       r_state;
  logic [3:0]       r_final;
  logic             w_load_use;
  logic             w_mispred;
  logic             w_ret_active;
  logic             w_run;
  logic             w_halt;
  logic             w_wdog;
  logic             w_retire;
  logic [CNT_W-1:0] w_cycle;
  logic             w_unused_micode;

  // memory-stage icode is carried in the bundle but not needed here
  assign w_unused_micode = ^bus.M_icode;

  assign w_load_use =
    ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
    (bus.E_dstM != RNONE) &&
    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));

  assign w_mispred    = (bus.E_icode == I_JXX) && !bus.e_cnd;
  assign w_ret_active = (bus.D_icode == I_RET) || (r_ret_cnt != 3'd0);
  assign w_run        = (r_state == ST_RUN);
  assign w_halt       = is_stop_stat(bus.W_stat);
  assign w_wdog       = (WDOG_CYCLES != 0) && (w_cycle == WDOG_LAST);
  assign w_retire     = (bus.W_stat == S_AOK) && (bus.W_icode != I_NOP);

  // remaining ret bubbles after the cycle ret itself sits in D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_cnt <= 3'd0;
    end else if ((bus.D_icode == I_RET) && (r_ret_cnt == 3'd0) &&
                 !w_load_use && !w_mispred) begin
      r_ret_cnt <= RET_LOAD;
    end else if (r_ret_cnt != 3'd0) begin
      r_ret_cnt <= r_ret_cnt - 3'd1;
    end
  end

  // run/stop/timeout; a retiring fault beats the watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_final <= S_AOK;
    end else if (w_run) begin
      if (w_halt) begin
        r_state <= ST_STOP;
        r_final <= bus.W_stat;
      end else if (w_wdog) begin
        r_state <= ST_TMO;
        r_final <= S_TMO;
      end
    end
  end

  // stage controls; once stopped the whole pipe freezes
  always_comb begin
    bus.F_stall  = 1'b1;
    bus.D_stall  = 1'b1;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b1;
    bus.M_bubble = 1'b1;
    bus.W_stall  = 1'b1;
    bus.set_cc   = 1'b0;
    if (w_run) begin
      bus.F_stall  = w_load_use || w_ret_active;
      bus.D_stall  = w_load_use;
      bus.D_bubble = w_mispred || (w_ret_active && !w_load_use);
      bus.E_bubble = w_mispred || w_load_use;
      bus.M_bubble = (bus.m_stat != S_AOK) || (bus.W_stat != S_AOK);
      bus.W_stall  = (bus.W_stat != S_AOK);
      bus.set_cc   = (bus.E_icode == I_OPQ) &&
                     (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);
    end
  end

  y86_sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(rst_n), .en(w_run), .q(w_cycle)
  );

  y86_sat_counter #(.W(CNT_W)) u_ret (
    .clk(clk), .rst_n(rst_n), .en(w_run && w_retire),
    .q(bus.retire_cnt)
  );

  y86_sat_counter #(.W(CNT_W)) u_stl (
    .clk(clk), .rst_n(rst_n), .en(w_run && bus.F_stall),
    .q(bus.stall_cnt)
  );

  y86_sat_counter #(.W(CNT_W)) u_mis (
    .clk(clk), .rst_n(rst_n), .en(w_run && w_mispred),
    .q(bus.mispred_cnt)
  );

  assign bus.cycle_cnt  = w_cycle;
  assign bus.state      = r_state;
  assign bus.final_stat = r_final;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed bench for y86_pipe_ctrl: three instances cover
// RET_BUBBLES=3, RET_BUBBLES=5 and a 10-cycle watchdog.
module tb_y86_pipe_ctrl;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst3 = 1'b1;
  logic rst5 = 1'b1;
  logic rstw = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   edges3 = 0;

  always #5 clk = ~clk;

  y86_pipe_ctrl_if #(.CNT_W(32)) if3 ();
  y86_pipe_ctrl_if #(.CNT_W(32)) if5 ();
  y86_pipe_ctrl_if #(.CNT_W(32)) ifw ();

  y86_pipe_ctrl #(.CNT_W(32), .RET_BUBBLES(3), .WDOG_CYCLES(0)) u_dut3 (
    .clk(clk), .rst_n(rst3), .bus(if3)
  );
  y86_pipe_ctrl #(.CNT_W(32), .RET_BUBBLES(5), .WDOG_CYCLES(0)) u_dut5 (
    .clk(clk), .rst_n(rst5), .bus(if5)
  );
  y86_pipe_ctrl #(.CNT_W(32), .RET_BUBBLES(3), .WDOG_CYCLES(10)) u_dutw (
    .clk(clk), .rst_n(rstw), .bus(ifw)
  );

  // reference count of clock edges seen by instance 3 out of reset
  always @(posedge clk or negedge rst3) begin
    if (!rst3) edges3 = 0;
    else edges3 = edges3 + 1;
  end

`define IDLE(x) \
  x.D_icode = I_NOP; x.d_srcA = RNONE; x.d_srcB = RNONE; \
  x.E_icode = I_NOP; x.E_dstM = RNONE; x.e_cnd = 1'b1; \
  x.M_icode = I_NOP; x.m_stat = S_AOK; x.W_stat = S_AOK; \
  x.W_icode = I_NOP;

  task automatic idle_all();
    `IDLE(if3)
    `IDLE(if5)
    `IDLE(ifw)
  endtask

  task automatic test_reset();
    idle_all();
    #2;
    rst3 = 1'b0; rst5 = 1'b0; rstw = 1'b0;
    #1;
    checks++; if (if3.state !== ST_RUN) begin failures++;
      $display("FAIL rst_state got=%0d exp=0", if3.state); end
    checks++; if (if3.final_stat !== S_AOK) begin failures++;
      $display("FAIL rst_final got=%0d exp=1", if3.final_stat); end
    checks++; if (if3.cycle_cnt !== 32'd0) begin failures++;
      $display("FAIL rst_cycle got=%0d exp=0", if3.cycle_cnt); end
    checks++; if ({if3.F_stall, if3.D_stall, if3.D_bubble, if3.E_bubble,
                   if3.M_bubble, if3.W_stall, if3.set_cc} !== 7'b0) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=0000000",
      {if3.F_stall, if3.D_stall, if3.D_bubble, if3.E_bubble,
       if3.M_bubble, if3.W_stall, if3.set_cc}); end
    @(negedge clk);
    rst3 = 1'b1; rst5 = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    if3.E_icode = I_MRMOVQ; if3.E_dstM = 4'h0; if3.d_srcA = 4'h0;
    #1;
    checks++; if ({if3.F_stall, if3.D_stall, if3.E_bubble, if3.D_bubble}
                  !== 4'b1110) begin failures++;
      $display("FAIL lu_mrmov got=%b exp=1110", {if3.F_stall,
      if3.D_stall, if3.E_bubble, if3.D_bubble}); end
    @(negedge clk);
    `IDLE(if3)
    if3.E_icode = I_POPQ; if3.E_dstM = 4'h3; if3.d_srcB = 4'h3;
    #1;
    checks++; if ({if3.F_stall, if3.D_stall, if3.E_bubble} !== 3'b111)
      begin failures++; $display("FAIL lu_popq got=%b exp=111",
      {if3.F_stall, if3.D_stall, if3.E_bubble}); end
    @(negedge clk);
    `IDLE(if3)
    if3.E_icode = I_MRMOVQ;
    #1;
    checks++; if ({if3.F_stall, if3.D_stall, if3.E_bubble} !== 3'b000)
      begin failures++; $display("FAIL lu_rnone got=%b exp=000",
      {if3.F_stall, if3.D_stall, if3.E_bubble}); end
    checks++; if (if3.retire_cnt !== 32'd0) begin failures++;
      $display("FAIL lu_retire got=%0d exp=0", if3.retire_cnt); end
    @(negedge clk);
    `IDLE(if3)
    if3.W_icode = I_OPQ;
    @(negedge clk);
    `IDLE(if3)
    #1;
    checks++; if (if3.retire_cnt !== 32'd1) begin failures++;
      $display("FAIL retire_one got=%0d exp=1", if3.retire_cnt); end
  endtask

  task automatic test_set_cc();
    @(negedge clk);
    if3.E_icode = I_OPQ;
    #1;
    checks++; if (if3.set_cc !== 1'b1) begin failures++;
      $display("FAIL setcc_ok got=%b exp=1", if3.set_cc); end
    if3.m_stat = S_ADR;
    #1;
    checks++; if ({if3.set_cc, if3.M_bubble, if3.W_stall} !== 3'b010)
      begin failures++; $display("FAIL setcc_madr got=%b exp=010",
      {if3.set_cc, if3.M_bubble, if3.W_stall}); end
    @(negedge clk);
    `IDLE(if3)
  endtask

  task automatic test_mispred();
    @(negedge clk);
    if3.E_icode = I_JXX; if3.e_cnd = 1'b1;
    #1;
    checks++; if ({if3.D_bubble, if3.E_bubble} !== 2'b00) begin
      failures++; $display("FAIL jxx_taken got=%b exp=00",
      {if3.D_bubble, if3.E_bubble}); end
    checks++; if (if3.mispred_cnt !== 32'd0) begin failures++;
      $display("FAIL mis_cnt0 got=%0d exp=0", if3.mispred_cnt); end
    @(negedge clk);
    if3.e_cnd = 1'b0; if3.D_icode = I_RET;
    #1;
    checks++; if ({if3.D_bubble, if3.E_bubble, if3.D_stall} !== 3'b110)
      begin failures++; $display("FAIL mis_bub got=%b exp=110",
      {if3.D_bubble, if3.E_bubble, if3.D_stall}); end
    @(negedge clk);
    `IDLE(if3)
    #1;
    checks++; if (if3.mispred_cnt !== 32'd1) begin failures++;
      $display("FAIL mis_cnt1 got=%0d exp=1", if3.mispred_cnt); end
    checks++; if (if3.F_stall !== 1'b0) begin failures++;
      $display("FAIL mis_ret_drop got=%b exp=0", if3.F_stall); end
  endtask

  task automatic test_ret(input int sel, input int n);
    int cnt;
    logic fs, db;
    cnt = 0;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (sel == 5) if5.D_icode = (i == 0) ? I_RET : I_NOP;
      else          if3.D_icode = (i == 0) ? I_RET : I_NOP;
      #1;
      fs = (sel == 5) ? if5.F_stall : if3.F_stall;
      db = (sel == 5) ? if5.D_bubble : if3.D_bubble;
      if (fs && db) cnt++;
    end
    checks++; if (cnt !== n) begin failures++;
      $display("FAIL ret_bubbles_%0d got=%0d exp=%0d", sel, cnt, n); end
  endtask

  task automatic test_ret_load_use();
    @(negedge clk);
    if3.D_icode = I_RET; if3.E_icode = I_MRMOVQ;
    if3.E_dstM = 4'h1; if3.d_srcA = 4'h1;
    #1;
    checks++; if ({if3.F_stall, if3.D_stall, if3.D_bubble} !== 3'b110)
      begin failures++; $display("FAIL ret_lu got=%b exp=110",
      {if3.F_stall, if3.D_stall, if3.D_bubble}); end
    @(negedge clk);
    `IDLE(if3)
    if3.D_icode = I_RET;
    #1;
    checks++; if ({if3.F_stall, if3.D_stall, if3.D_bubble} !== 3'b101)
      begin failures++; $display("FAIL ret_after_lu got=%b exp=101",
      {if3.F_stall, if3.D_stall, if3.D_bubble}); end
    @(negedge clk);
    if3.D_icode = I_NOP;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if3.F_stall !== 1'b0) begin failures++;
      $display("FAIL ret_lu_drain got=%b exp=0", if3.F_stall); end
  endtask

  task automatic test_halt();
    int exp_cyc;
    @(negedge clk);
    if3.W_stat = S_HLT; if3.W_icode = I_HALT;
    #1;
    checks++; if ({if3.state, if3.W_stall, if3.M_bubble} !== 4'b0011)
      begin failures++; $display("FAIL halt_pre got=%b exp=0011",
      {if3.state, if3.W_stall, if3.M_bubble}); end
    @(negedge clk);
    `IDLE(if3)
    if3.E_icode = I_OPQ;
    #1;
    exp_cyc = edges3;
    checks++; if (if3.state !== ST_STOP) begin failures++;
      $display("FAIL halt_state got=%0d exp=1", if3.state); end
    checks++; if (if3.final_stat !== S_HLT) begin failures++;
      $display("FAIL halt_final got=%0d exp=2", if3.final_stat); end
    checks++; if ({if3.F_stall, if3.D_stall, if3.W_stall, if3.E_bubble,
                   if3.M_bubble, if3.D_bubble, if3.set_cc} !== 7'b1111100)
      begin failures++; $display("FAIL halt_ctrl got=%b exp=1111100",
      {if3.F_stall, if3.D_stall, if3.W_stall, if3.E_bubble,
       if3.M_bubble, if3.D_bubble, if3.set_cc}); end
    checks++; if (if3.cycle_cnt !== 32'(exp_cyc)) begin failures++;
      $display("FAIL halt_cyc got=%0d exp=%0d", if3.cycle_cnt, exp_cyc); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (if3.cycle_cnt !== 32'(exp_cyc)) begin failures++;
      $display("FAIL halt_frozen got=%0d exp=%0d", if3.cycle_cnt,
      exp_cyc); end
  endtask

  task automatic test_reset_in_stop();
    @(negedge clk);
    `IDLE(if3)
    if3.D_icode = I_RET;
    @(negedge clk);
    if3.D_icode = I_NOP;
    #1;
    rst3 = 1'b0;
    #1;
    checks++; if ({if3.state, if3.final_stat} !== {ST_RUN, S_AOK}) begin
      failures++; $display("FAIL rst_stop_state got=%b exp=%b",
      {if3.state, if3.final_stat}, {ST_RUN, S_AOK}); end
    checks++; if ({if3.cycle_cnt, if3.stall_cnt, if3.retire_cnt,
                   if3.mispred_cnt} !== 128'd0) begin failures++;
      $display("FAIL rst_stop_cnt got=%0d/%0d/%0d/%0d exp=0",
      if3.cycle_cnt, if3.stall_cnt, if3.retire_cnt, if3.mispred_cnt); end
    checks++; if (if3.F_stall !== 1'b0) begin failures++;
      $display("FAIL rst_stop_fstall got=%b exp=0", if3.F_stall); end
    @(negedge clk);
    rst3 = 1'b1;
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    rstw = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    checks++; if ({ifw.state, ifw.cycle_cnt} !== {ST_RUN, 32'd9}) begin
      failures++; $display("FAIL wdog_pre got=%0d/%0d exp=0/9",
      ifw.state, ifw.cycle_cnt); end
    @(negedge clk);
    #1;
    checks++; if (ifw.state !== ST_TMO) begin failures++;
      $display("FAIL wdog_state got=%0d exp=2", ifw.state); end
    checks++; if ({ifw.cycle_cnt, ifw.final_stat} !== {32'd10, S_TMO})
      begin failures++; $display("FAIL wdog_cnt got=%0d/%0d exp=10/5",
      ifw.cycle_cnt, ifw.final_stat); end
    @(negedge clk);
    #1;
    checks++; if ({ifw.cycle_cnt, ifw.F_stall} !== {32'd10, 1'b1}) begin
      failures++; $display("FAIL wdog_frozen got=%0d/%b exp=10/1",
      ifw.cycle_cnt, ifw.F_stall); end
  endtask

  task automatic test_stop_beats_wdog();
    rstw = 1'b0;
    @(negedge clk);
    rstw = 1'b1;
    repeat (9) @(negedge clk);
    ifw.W_stat = S_ADR;
    @(negedge clk);
    `IDLE(ifw)
    #1;
    checks++; if ({ifw.state, ifw.final_stat} !== {ST_STOP, S_ADR}) begin
      failures++; $display("FAIL stop_wins got=%0d/%0d exp=1/3",
      ifw.state, ifw.final_stat); end
  endtask

  task automatic test_ret5_stalls();
    checks++; if ({if5.stall_cnt, if5.mispred_cnt} !== {32'd5, 32'd0})
      begin failures++; $display("FAIL ret5_stalls got=%0d/%0d exp=5/0",
      if5.stall_cnt, if5.mispred_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_set_cc();
    test_mispred();
    test_ret(3, 3);
    test_ret(5, 5);
    test_ret5_stalls();
    test_ret_load_use();
    test_halt();
    test_reset_in_stop();
    test_watchdog();
    test_stop_beats_wdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_pipe_ctrl.md
Name: y86_pipe_ctrl

Overview:
- Synthesizable, parametrised successor to the five-stage Y86-64 pipeline control logic.
- Generates stall, bubble and condition-code enables from D/E/M/W stage state.
- Generalises the ret penalty to a configurable bubble count.
- Replaces simulation-only stat handling with a run/stop/timeout state machine, latched final status and saturating performance counters.
- Sits beside the pipeline registers in the processor top; every stage register takes its stall/bubble from this block.

Parameters:
- CNT_W, 32, width of each performance counter.
- RET_BUBBLES, 3, total D-stage bubbles inserted per ret (legal range 1..7).
- WDOG_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- D_icode  in  4  icode in decode.
- d_srcA  in  4  decode source A register id.
- d_srcB  in  4  decode source B register id.
- E_icode  in  4  icode in execute.
- E_dstM  in  4  execute memory destination register.
- e_cnd  in  1  execute condition result.
- M_icode  in  4  icode in memory.
- m_stat  in  4  memory-stage status after access.
- W_stat  in  4  writeback status.
- W_icode  in  4  writeback icode.
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  stage controls.
- set_cc  out  1  condition-code write enable.
- state  out  2  0 RUN, 1 STOP, 2 TIMEOUT.
- final_stat  out  4  status latched on leaving RUN.
- cycle_cnt, retire_cnt, stall_cnt, mispred_cnt  out  CNT_W each  performance counters.

Behaviour:
- Encodings:
  - Stat: AOK=1, HLT=2, ADR=3, INS=4, TMO=5.
  - Icode: HALT=0, NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=B.
  - RNONE=F.
- Reset: state=RUN, final_stat=AOK, ret_cnt=0, all counters 0. Outputs follow from this combinationally.
- load_use = E_icode in {MRMOVQ,POPQ} and E_dstM != RNONE and E_dstM in {d_srcA,d_srcB}.
- mispred = E_icode==JXX and !e_cnd.
- ret_active = (D_icode==RET) or ret_cnt != 0.
- ret_cnt (3-bit register):
  - Loads RET_BUBBLES-1 on an edge where D_icode==RET, ret_cnt==0, !load_use and !mispred.
  - Otherwise decrements toward 0 when nonzero.
  - Mispred while ret_cnt != 0 leaves the decrement unchanged.
  - Net effect: RET_BUBBLES bubble cycles, counting the cycle ret sits in D.
- Outputs in RUN:
  - F_stall = load_use or ret_active.
  - D_stall = load_use.
  - D_bubble = mispred or (ret_active and !load_use).
  - E_bubble = mispred or load_use.
  - M_bubble = m_stat!=AOK or W_stat!=AOK.
  - W_stall = W_stat!=AOK.
  - set_cc = E_icode==OPQ and m_stat==AOK and W_stat==AOK.
  - D_stall and D_bubble are never both 1.
- Outputs in STOP/TIMEOUT:
  - F_stall=D_stall=W_stall=1, M_bubble=E_bubble=1, D_bubble=0, set_cc=0.
  - The pipeline is frozen.
- FSM:
  - RUN→STOP on an edge where W_stat in {HLT,ADR,INS}; final_stat<=W_stat.
  - RUN→TIMEOUT on an edge where WDOG_CYCLES!=0 and cycle_cnt==WDOG_CYCLES-1; final_stat<=TMO.
  - If both hold on the same edge, STOP wins.
  - STOP and TIMEOUT are absorbing; only rst_n exits them.
- Counters advance only while state==RUN (including the exiting edge) and saturate at all-ones:
  - cycle_cnt: +1 every edge.
  - retire_cnt: +1 when W_stat==AOK and W_icode!=NOP.
  - stall_cnt: +1 when F_stall.
  - mispred_cnt: +1 when mispred.
- Reset asserted mid-operation clears everything asynchronously. Pending ret bubbles are discarded.

Decomposition:
- Package y86_pkg holds icode constants, stat constants, RNONE and the state enum.
- Shared with fetch/decode/execute/memory.
- One sub-module, y86_sat_counter (params W; ports clk, rst_n, en, q), instantiated four times.

Test Plan:
- mrmovq to rax in E, D reads d_srcA=0 → one cycle of F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; retire_cnt is unaffected by the bubble.
- ret reaches D with RET_BUBBLES=3 → F_stall=D_bubble=1 for exactly 3 cycles; rerun with RET_BUBBLES=5 → 5 cycles.
- jXX in E with e_cnd=0 → D_bubble=E_bubble=1 for one cycle, mispred_cnt 0→1; same with ret in D → ret_cnt stays 0.
- halt retires (W_stat=HLT) → next edge state=STOP, final_stat=2, all stalls asserted, cycle_cnt frozen.
- WDOG_CYCLES=10, loop never halts → state=TIMEOUT after edge 10, cycle_cnt=10, final_stat=5.
- Assert rst_n low in STOP with ret_cnt=2 → immediately state=RUN, counters 0, F_stall=0.
